// File: rtl/pn3_checker.sv
// -----------------------------------------------------------------------------
// pn3_checker
//
// Receive-side checker for the PN3 test pattern (x^3 + x^2 + 1, period 7).
// It self-synchronises to the incoming serial stream, declares lock once
// enough consecutive bits have been predicted correctly, and then counts the
// compared bits and bit errors for BER measurement. While locked the history
// register runs as a flywheel on its own predictions, so a single corrupted
// bit costs exactly one error instead of poisoning the next predictions.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous, active-low reset
//   enable     in   checker enable; low returns the checker to IDLE
//   bit_in     in   received PN bit, sampled only when bit_valid = 1
//   bit_valid  in   one-cycle strobe per received bit (any spacing)
//   clear_cnt  in   synchronous clear of bit_count / err_count
//   locked     out  checker locked to the sequence (state == LOCKED)
//   err_pulse  out  one-cycle pulse per errored bit while locked
//   bit_count  out  bits compared while locked, saturating
//   err_count  out  errored bits while locked, saturating
//   state      out  00 IDLE, 01 SEED, 10 SYNC, 11 LOCKED
// -----------------------------------------------------------------------------
module pn3_checker #(
  parameter int LOCK_COUNT = 8,   // consecutive matches to lock (1..255)
  parameter int LOSS_COUNT = 4,   // consecutive errors to lose lock (1..255)
  parameter int CNT_W      = 32   // width of the bit / error counters
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEED   = 2'b01,
    ST_SYNC   = 2'b10,
    ST_LOCKED = 2'b11
  } state_e;

  // Run-length thresholds. The run counters are 8 bits wide because both
  // thresholds are limited to 255; a counter never exceeds threshold - 1.
  localparam logic [7:0]       LOCK_TGT = 8'(LOCK_COUNT);
  localparam logic [7:0]       LOSS_TGT = 8'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e             state_q,     state_d;
  logic [2:0]         hist_q,      hist_d;       // {oldest, middle, newest}
  logic [1:0]         seed_cnt_q,  seed_cnt_d;   // bits taken while seeding
  logic [7:0]         match_cnt_q, match_cnt_d;  // consecutive matches (SYNC)
  logic [7:0]         miss_cnt_q,  miss_cnt_d;   // consecutive errors (LOCKED)
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               locked_q,    locked_d;
  logic               err_pulse_q, err_pulse_d;

  // ---------------------------------------------------------------------------
  // Shared prediction logic
  // ---------------------------------------------------------------------------
  logic       exp_bit;     // predicted next bit: o(n-2) xor o(n)
  logic       rx_err;      // received bit disagrees with the prediction
  logic [2:0] hist_rx;     // history after shifting in the received bit
  logic [2:0] hist_fw;     // history after shifting in the predicted bit
  logic [7:0] match_inc;
  logic [7:0] miss_inc;
  logic       lock_bit;    // a valid bit is being compared while locked

  assign exp_bit   = hist_q[2] ^ hist_q[0];
  assign rx_err    = bit_in ^ exp_bit;
  assign hist_rx   = {hist_q[1:0], bit_in};
  assign hist_fw   = {hist_q[1:0], exp_bit};
  assign match_inc = match_cnt_q + 8'd1;
  assign miss_inc  = miss_cnt_q + 8'd1;
  assign lock_bit  = enable & bit_valid & (state_q == ST_LOCKED);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: sequencing, history shifting and run counters
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    if (!enable) begin
      // Dropping enable abandons any synchronisation in progress; a bit
      // strobed in this cycle is deliberately ignored.
      state_d     = ST_IDLE;
      hist_d      = '0;
      seed_cnt_d  = '0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SEED;
          hist_d     = '0;
          seed_cnt_d = '0;
        end

        ST_SEED: begin
          if (bit_valid) begin
            hist_d = hist_rx;
            if (seed_cnt_q == 2'd2) begin
              // Third seed bit. An all-zero history is the LFSR lock-up
              // state and can never predict the sequence, so reseed.
              seed_cnt_d = '0;
              if (hist_rx != 3'b000) begin
                state_d     = ST_SYNC;
                match_cnt_d = '0;
              end
            end else begin
              seed_cnt_d = seed_cnt_q + 2'd1;
            end
          end
        end

        ST_SYNC: begin
          if (bit_valid) begin
            hist_d = hist_rx;
            if (hist_rx == 3'b000) begin
              // Received bits drove the history into lock-up.
              state_d     = ST_SEED;
              seed_cnt_d  = '0;
              match_cnt_d = '0;
            end else if (!rx_err) begin
              if (match_inc == LOCK_TGT) begin
                state_d     = ST_LOCKED;
                match_cnt_d = '0;
                miss_cnt_d  = '0;
              end else begin
                match_cnt_d = match_inc;
              end
            end else begin
              match_cnt_d = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (bit_valid) begin
            // Flywheel: keep predicting from our own sequence, not from the
            // received bit, so one bad bit is counted exactly once.
            hist_d = hist_fw;
            if (rx_err) begin
              if (miss_inc == LOSS_TGT) begin
                state_d    = ST_SEED;
                seed_cnt_d = '0;
                miss_cnt_d = '0;
              end else begin
                miss_cnt_d = miss_inc;
              end
            end else begin
              miss_cnt_d = '0;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: lock flag, error pulse and saturating BER counters
  // ---------------------------------------------------------------------------
  always_comb begin
    locked_d    = (state_d == ST_LOCKED);
    err_pulse_d = lock_bit & rx_err;
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;

    if (clear_cnt) begin
      // A clear wins over a bit compared in the same cycle; that bit still
      // drives the state machine and err_pulse, it just is not counted.
      bit_count_d = '0;
      err_count_d = '0;
    end else if (lock_bit) begin
      if (bit_count_q != CNT_MAX) begin
        bit_count_d = bit_count_q + 1'b1;
      end
      if (rx_err && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  // Output registers. The counters deliberately survive enable=0 and loss of
  // lock; only reset and clear_cnt zero them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign bit_count = bit_count_q;
  assign err_count = err_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pn3_checker.sv
// -----------------------------------------------------------------------------
// tb_pn3_checker
//
// Scoreboard bench for pn3_checker. Two instances share the same stimulus: a
// full-width build (CNT_W=32) and a narrow build (CNT_W=4) whose counters
// reach saturation. A behavioural model predicts the outputs after every
// clock; the driver pushes that prediction into a queue and an independent
// monitor pops and compares it on the falling edge. Directed checks against
// hand-derived constants cover the lock/loss timing points.
// -----------------------------------------------------------------------------
module tb_pn3_checker;

  localparam int LOCK_COUNT = 8;
  localparam int LOSS_COUNT = 4;
  localparam int CNT_W      = 32;
  localparam int CNT_W_N    = 4;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic enable    = 1'b0;
  logic bit_in    = 1'b0;
  logic bit_valid = 1'b0;
  logic clear_cnt = 1'b0;

  logic               locked,   err_pulse;
  logic [CNT_W-1:0]   bit_count, err_count;
  logic [1:0]         state;
  logic               locked_n, err_pulse_n;
  logic [CNT_W_N-1:0] bit_count_n, err_count_n;
  logic [1:0]         state_n;

  always #5 clk = ~clk;

  pn3_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bit_in),
    .bit_valid(bit_valid), .clear_cnt(clear_cnt), .locked(locked),
    .err_pulse(err_pulse), .bit_count(bit_count), .err_count(err_count),
    .state(state)
  );

  pn3_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(CNT_W_N)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bit_in),
    .bit_valid(bit_valid), .clear_cnt(clear_cnt), .locked(locked_n),
    .err_pulse(err_pulse_n), .bit_count(bit_count_n), .err_count(err_count_n),
    .state(state_n)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [1:0]         st;
    logic               lk;
    logic               ep;
    logic [CNT_W-1:0]   bc;
    logic [CNT_W-1:0]   ec;
    logic [CNT_W_N-1:0] bcn;
    logic [CNT_W_N-1:0] ecn;
  } exp_t;

  exp_t sb_q[$];

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_SEED = 1, M_SYNC = 2, M_LOCK = 3;

  int     m_mode;
  bit     m_hist[$];     // last three accepted bits, [0] oldest .. [2] newest
  int     m_seedn, m_run, m_miss;
  longint m_bits, m_errs;
  bit     m_pulse;

  task automatic model_clear_run();
    m_hist  = '{1'b0, 1'b0, 1'b0};
    m_seedn = 0;
    m_run   = 0;
    m_miss  = 0;
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    model_clear_run();
    m_bits  = 0;
    m_errs  = 0;
    m_pulse = 0;
  endtask

  task automatic model_shift(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  function automatic bit model_hist_zero();
    return (m_hist[0] == 1'b0) && (m_hist[1] == 1'b0) && (m_hist[2] == 1'b0);
  endfunction

  task automatic model_step(input bit en, input bit v, input bit b, input bit clr);
    bit e;
    m_pulse = 0;
    if (clr) begin
      m_bits = 0;
      m_errs = 0;
    end
    if (!en) begin
      m_mode = M_IDLE;
      model_clear_run();
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_SEED;
        M_SEED: if (v) begin
          model_shift(b);
          m_seedn++;
          if (m_seedn == 3) begin
            m_seedn = 0;
            if (!model_hist_zero()) begin
              m_mode = M_SYNC;
              m_run  = 0;
            end
          end
        end
        M_SYNC: if (v) begin
          e = m_hist[0] ^ m_hist[2];
          model_shift(b);
          m_run = (b == e) ? m_run + 1 : 0;
          if (model_hist_zero()) begin
            m_mode  = M_SEED;
            m_seedn = 0;
            m_run   = 0;
          end else if (m_run == LOCK_COUNT) begin
            m_mode = M_LOCK;
            m_miss = 0;
          end
        end
        default: if (v) begin
          e = m_hist[0] ^ m_hist[2];
          model_shift(e);
          if (!clr) m_bits++;
          if (b != e) begin
            m_pulse = 1;
            if (!clr) m_errs++;
            m_miss++;
            if (m_miss == LOSS_COUNT) begin
              m_mode  = M_SEED;
              m_seedn = 0;
              m_miss  = 0;
            end
          end else begin
            m_miss = 0;
          end
        end
      endcase
    end
  endtask

  function automatic longint clamp(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit pn_seq [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  int pn_idx = 0;

  function automatic bit pn_next();
    bit r;
    r      = pn_seq[pn_idx];
    pn_idx = (pn_idx + 1) % 7;
    return r;
  endfunction

  // One clock: drive inputs, let the edge happen, step the model, push the
  // prediction for the monitor.
  task automatic cycle(input bit en, input bit v, input bit b, input bit clr);
    exp_t x;
    enable    = en;
    bit_valid = v;
    bit_in    = b;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else        model_step(en, v, b, clr);
    x.st  = 2'(m_mode);
    x.lk  = (m_mode == M_LOCK);
    x.ep  = m_pulse;
    x.bc  = CNT_W'(clamp(m_bits, CNT_W));
    x.ec  = CNT_W'(clamp(m_errs, CNT_W));
    x.bcn = CNT_W_N'(clamp(m_bits, CNT_W_N));
    x.ecn = CNT_W_N'(clamp(m_errs, CNT_W_N));
    sb_q.push_back(x);
  endtask

  // n PN bits, each followed by `gap` idle cycles, each inverted with
  // probability err_pct percent.
  task automatic send_bits(input int n, input int gap, input int err_pct);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = pn_next();
      if (int'($urandom_range(0, 99)) < err_pct) b = ~b;
      cycle(1'b1, 1'b1, b, 1'b0);
      for (int g = 0; g < gap; g++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic restart_stream();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);   // back to IDLE
    cycle(1'b1, 1'b0, 1'b0, 1'b0);   // IDLE -> SEED
    pn_idx = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every DUT output against the queued prediction
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("sb_state",       state,       x.st);
        check("sb_locked",      locked,      x.lk);
        check("sb_err_pulse",   err_pulse,   x.ep);
        check("sb_bit_count",   bit_count,   x.bc);
        check("sb_err_count",   err_count,   x.ec);
        check("sb_n_locked",    locked_n,    x.lk);
        check("sb_n_err_pulse", err_pulse_n, x.ep);
        check("sb_n_bit_count", bit_count_n, x.bcn);
        check("sb_n_err_count", err_count_n, x.ecn);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  initial begin : driver
    bit saw_lock;
    bit b;
    bit en_r, v_r, c_r;

    model_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_state",     state,     0);
    check("rst_locked",    locked,    0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_bit_count", bit_count, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;

    // Error-free stream: lock on the 11th bit, then 70 counted bits.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    pn_idx = 0;
    send_bits(10, 0, 0);
    check("lock_after_10", locked, 0);
    send_bits(1, 0, 0);
    check("lock_after_11", locked, 1);
    check("lock_state", state, 3);
    check("lock_bitcnt0", bit_count, 0);
    send_bits(70, 0, 0);
    check("clean_bit_count", bit_count, 70);
    check("clean_err_count", err_count, 0);

    // Single inverted bit while locked.
    send_bits(1, 0, 100);
    check("single_err_pulse", err_pulse, 1);
    check("single_err_count", err_count, 1);
    check("single_locked",    locked,    1);
    send_bits(10, 0, 0);
    check("single_after_err",   err_count, 1);
    check("single_after_bits",  bit_count, 81);
    check("single_after_pulse", err_pulse, 0);

    // Four consecutive errors force resynchronisation.
    send_bits(3, 0, 100);
    check("loss3_locked", locked,    1);
    check("loss3_err",    err_count, 4);
    send_bits(1, 0, 100);
    check("loss4_locked", locked,    0);
    check("loss4_state",  state,     1);
    check("loss4_err",    err_count, 5);
    check("loss4_bits",   bit_count, 85);
    send_bits(10, 0, 0);
    check("relock_after_10", locked, 0);
    send_bits(1, 0, 0);
    check("relock_after_11", locked, 1);
    check("relock_bits_held", bit_count, 85);

    // enable low: IDLE, counters hold. Then an all-zero stream never locks.
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("dis_state",  state,     0);
    check("dis_locked", locked,    0);
    check("dis_bits",   bit_count, 85);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    saw_lock = 1'b0;
    repeat (30) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      if (locked) saw_lock = 1'b1;
    end
    check("zero_never_lock", saw_lock, 0);
    check("zero_state_seed", state, 1);

    // clear_cnt together with an errored bit while locked.
    restart_stream();
    send_bits(11, 0, 0);
    check("clr_locked", locked, 1);
    send_bits(5, 0, 0);
    b = ~pn_next();
    cycle(1'b1, 1'b1, b, 1'b1);
    check("clr_bit_count", bit_count, 0);
    check("clr_err_count", err_count, 0);
    check("clr_err_pulse", err_pulse, 1);
    check("clr_locked_kept", locked, 1);
    send_bits(3, 0, 0);
    check("clr_recount", bit_count, 3);
    check("clr_err_after", err_count, 0);

    // Bits strobed every 5 cycles: lock still on the 11th valid bit.
    restart_stream();
    send_bits(10, 4, 0);
    check("spaced_after_10", locked, 0);
    send_bits(1, 4, 0);
    check("spaced_after_11", locked, 1);

    // Heavily errored stream: the narrow counters saturate.
    send_bits(300, 0, 25);
    if (m_errs >= 15) check("sat_err_n", err_count_n, 15);
    if (m_bits >= 15) check("sat_bit_n", bit_count_n, 15);

    // Randomised traffic: enable drops, spacing, errors, clears.
    for (int i = 0; i < 600; i++) begin
      en_r = (int'($urandom_range(0, 99)) < 97);
      v_r  = (int'($urandom_range(0, 99)) < 60);
      c_r  = (int'($urandom_range(0, 99)) < 3);
      b    = v_r ? pn_next() : 1'($urandom_range(0, 1));
      if (v_r && (int'($urandom_range(0, 99)) < 10)) b = ~b;
      cycle(en_r, v_r, b, c_r);
    end

    // Asynchronous reset in the middle of a locked stream.
    restart_stream();
    send_bits(20, 0, 0);
    check("pre_rst_locked", locked, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_state",     state,       0);
    check("arst_locked",    locked,      0);
    check("arst_err_pulse", err_pulse,   0);
    check("arst_bit_count", bit_count,   0);
    check("arst_err_count", err_count,   0);
    check("arst_n_bits",    bit_count_n, 0);
    check("arst_n_errs",    err_count_n, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    pn_idx = 0;
    send_bits(11, 0, 0);
    check("post_rst_lock", locked, 1);
    check("post_rst_bits", bit_count, 0);

    @(negedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
